// File: rtl/approx_softmax_unit.sv
// Approximate softmax / 2^x / 1/x activation unit, 3 register stages:
// exp+max+sum | reciprocal of sum | normalising multiply.

module asu_exp2 #(
    parameter int NUM_WIDTH  = 32,
    parameter int FRAC_WIDTH = 24,
    parameter int INT_WIDTH  = 8
) (
    input  logic signed [NUM_WIDTH:0]   x,
    output logic        [NUM_WIDTH-1:0] y
);
    localparam int KW = NUM_WIDTH - FRAC_WIDTH + 1;
    localparam logic [NUM_WIDTH-1:0]  MAXV  = {1'b0, {(NUM_WIDTH-1){1'b1}}};
    localparam logic signed [KW-1:0]  K_SAT = KW'(INT_WIDTH - 1);
    localparam logic signed [KW-1:0]  K_MIN = KW'(-FRAC_WIDTH);

    logic signed [KW-1:0]        k;
    logic        [KW-1:0]        sh;
    logic        [NUM_WIDTH-1:0] wide;

    // (1+f) * 2^k; saturated cases never look at the shifted value
    always_comb begin
        k    = x[NUM_WIDTH:FRAC_WIDTH];
        wide = NUM_WIDTH'({1'b1, x[FRAC_WIDTH-1:0]});
        if (!k[KW-1]) begin
            sh   = k;
            wide = wide << sh;
        end else begin
            sh   = -k;
            wide = wide >> sh;
        end
        if (k >= K_SAT)
            y = MAXV;
        else if (k < K_MIN)
            y = '0;
        else
            y = wide;
    end
endmodule

module asu_recip #(
    parameter int NUM_WIDTH  = 32,
    parameter int FRAC_WIDTH = 24
) (
    input  logic [NUM_WIDTH-1:0] x,
    output logic [NUM_WIDTH-1:0] y
);
    localparam logic [NUM_WIDTH-1:0] MAXV = {1'b0, {(NUM_WIDTH-1){1'b1}}};

    int                          p;
    logic [FRAC_WIDTH-1:0]       m;
    logic [FRAC_WIDTH:0]         minv;
    logic [2*NUM_WIDTH-1:0]      wide;

    always_comb begin
        p = 0;
        for (int i = 0; i < NUM_WIDTH-1; i++)
            if (x[i]) p = i;
        // mantissa bits below the leading one, aligned to the binary point
        if (p <= FRAC_WIDTH)
            m = FRAC_WIDTH'({{NUM_WIDTH{1'b0}}, x} << (FRAC_WIDTH - p));
        else
            m = FRAC_WIDTH'({{NUM_WIDTH{1'b0}}, x} >> (p - FRAC_WIDTH));
        minv = (FRAC_WIDTH+1)'(1 << FRAC_WIDTH) - (FRAC_WIDTH+1)'(m >> 1);
        wide = (2*NUM_WIDTH)'(minv);
        if (p <= FRAC_WIDTH)
            wide = wide << (FRAC_WIDTH - p);
        else
            wide = wide >> (p - FRAC_WIDTH);
        if (x[NUM_WIDTH-1] || x == '0 || wide > (2*NUM_WIDTH)'(MAXV))
            y = MAXV;
        else
            y = wide[NUM_WIDTH-1:0];
    end
endmodule

module approx_softmax_unit #(
    parameter int NUM_WIDTH   = 32,
    parameter int FRAC_WIDTH  = 24,
    parameter int INT_WIDTH   = 8,
    parameter int OUTPUT_SIZE = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [1:0]                       op,
    input  logic [OUTPUT_SIZE*NUM_WIDTH-1:0] x_pk,
    output logic                             out_valid,
    output logic [OUTPUT_SIZE*NUM_WIDTH-1:0] res_pk
);
    localparam int STAGES = 2;
    localparam logic [1:0] MODE_SMAX = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd2;

    logic [OUTPUT_SIZE-1:0][NUM_WIDTH-1:0] x, exp_v, inv_v, s1_val, s2_val, res_v;
    logic [OUTPUT_SIZE-1:0][NUM_WIDTH:0]   exp_arg;
    logic signed [NUM_WIDTH-1:0]           mx;
    logic [NUM_WIDTH-1:0]                  sum_c, s1_sum, r_c, s2_r;
    logic [1:0]                            mode_c, s1_mode, s2_mode;
    logic [STAGES:0]                       vld_pipe;

    assign x         = x_pk;
    assign mode_c    = (op == 2'd3) ? MODE_SMAX : op;
    assign out_valid = vld_pipe[STAGES];

    always_comb begin
        mx = x[0];
        for (int i = 1; i < OUTPUT_SIZE; i++)
            if ($signed(x[i]) > mx) mx = x[i];
    end

    // sum of exps lies in [1, OUTPUT_SIZE], so NUM_WIDTH bits cannot wrap
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < OUTPUT_SIZE; i++)
            sum_c = sum_c + exp_v[i];
    end

    genvar g;
    generate
        for (g = 0; g < OUTPUT_SIZE; g++) begin : g_lane
            assign exp_arg[g] = (mode_c == MODE_SMAX)
                              ? ({x[g][NUM_WIDTH-1], x[g]} - {mx[NUM_WIDTH-1], mx})
                              : {x[g][NUM_WIDTH-1], x[g]};

            asu_exp2 #(.NUM_WIDTH(NUM_WIDTH), .FRAC_WIDTH(FRAC_WIDTH), .INT_WIDTH(INT_WIDTH))
                u_exp (.x(exp_arg[g]), .y(exp_v[g]));

            asu_recip #(.NUM_WIDTH(NUM_WIDTH), .FRAC_WIDTH(FRAC_WIDTH))
                u_inv (.x(x[g]), .y(inv_v[g]));

            assign res_v[g] = (s2_mode == MODE_SMAX)
                            ? NUM_WIDTH'(((2*NUM_WIDTH)'(s2_val[g]) * (2*NUM_WIDTH)'(s2_r)) >> FRAC_WIDTH)
                            : s2_val[g];
        end
    endgenerate

    asu_recip #(.NUM_WIDTH(NUM_WIDTH), .FRAC_WIDTH(FRAC_WIDTH))
        u_sum_inv (.x(s1_sum), .y(r_c));

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_val   <= '0;
            s1_sum   <= '0;
            s1_mode  <= '0;
            s2_val   <= '0;
            s2_r     <= '0;
            s2_mode  <= '0;
            res_pk   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
            if (in_valid) begin
                s1_val  <= (mode_c == MODE_INV) ? inv_v : exp_v;
                s1_sum  <= sum_c;
                s1_mode <= mode_c;
            end
            if (vld_pipe[0]) begin
                s2_val  <= s1_val;
                s2_r    <= r_c;
                s2_mode <= s1_mode;
            end
            if (vld_pipe[1])
                res_pk <= res_v;
        end
    end
endmodule

// File: tb/tb_approx_softmax_unit.sv
// Random + directed bench for approx_softmax_unit against an integer-arithmetic model.

module tb_approx_softmax_unit;
    localparam longint ONE  = 64'd1 << 24;
    localparam longint MAXV = 64'h7FFF_FFFF;

    logic        clk = 0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  op;
    logic [95:0] x_pk;
    logic        out_valid;
    logic [95:0] res_pk;

    approx_softmax_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op),
        .x_pk(x_pk), .out_valid(out_valid), .res_pk(res_pk)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [95:0] res;
    } sb_t;

    sb_t         sb[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [95:0] last_res = '0;
    logic [95:0] pend_res;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
        end
    endtask

    function automatic longint floor_div(longint a, longint b);
        longint q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint m_exp(longint v);
        longint k = floor_div(v, ONE);
        longint f = v - k * ONE;
        if (k >= 7)   return MAXV;
        if (k < -24)  return 0;
        if (k >= 0)   return (ONE + f) * (64'd1 << k);
        return (ONE + f) / (64'd1 << (-k));
    endfunction

    function automatic longint m_inv(longint v);
        int     p = 0;
        longint e, m, minv, r;
        if (v <= 0) return MAXV;
        while ((64'd1 << (p + 1)) <= v) p++;
        e = p - 24;
        m = (e >= 0) ? v / (64'd1 << e) - ONE : v * (64'd1 << (-e)) - ONE;
        minv = ONE - m / 2;
        r = (e >= 0) ? minv / (64'd1 << e) : minv * (64'd1 << (-e));
        return (r > MAXV) ? MAXV : r;
    endfunction

    function automatic logic [95:0] model(input logic [1:0] o, input int xs[3]);
        logic [95:0] v;
        longint mx, s, r, e[3];
        v = '0;
        if (o == 2'd1) begin
            for (int i = 0; i < 3; i++) v[i*32 +: 32] = 32'(m_exp(longint'(xs[i])));
        end else if (o == 2'd2) begin
            for (int i = 0; i < 3; i++) v[i*32 +: 32] = 32'(m_inv(longint'(xs[i])));
        end else begin
            mx = xs[0];
            for (int i = 1; i < 3; i++) if (longint'(xs[i]) > mx) mx = xs[i];
            s = 0;
            for (int i = 0; i < 3; i++) begin
                e[i] = m_exp(longint'(xs[i]) - mx);
                s = s + e[i];
            end
            r = m_inv(s);
            for (int i = 0; i < 3; i++) v[i*32 +: 32] = 32'((e[i] * r) / ONE);
        end
        return v;
    endfunction

    function automatic logic [95:0] pack3(input int a, input int b, input int c);
        logic [95:0] v;
        v = {c, b, a};
        return v;
    endfunction

    // One active edge: record what was accepted, then check outputs 1ns later.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst) begin
            sb.delete();
            last_res = '0;
        end else if (in_valid) begin
            sb.push_back('{cyc: cyc + 2, res: pend_res});
        end
        #1;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            chk("valid", {95'd0, out_valid}, 96'd1);
            chk("res", res_pk, sb[0].res);
            last_res = sb[0].res;
            void'(sb.pop_front());
        end else begin
            chk("idle_valid", {95'd0, out_valid}, 96'd0);
            chk("hold", res_pk, last_res);
        end
    endtask

    task automatic drive(input logic [1:0] o, input int xs[3], input logic [95:0] want);
        in_valid = 1;
        op       = o;
        x_pk     = pack3(xs[0], xs[1], xs[2]);
        pend_res = want;
    endtask

    int          dir_x[12][3];
    logic [1:0]  dir_op[12];
    logic [95:0] dir_res[12];
    int          xs[3];
    logic [1:0]  o;

    initial begin
        dir_op[0]  = 2'd1; dir_x[0]  = '{3, 32'h03000000, 32'hFD000000};
        dir_res[0] = pack3(32'h01000003, 32'h08000000, 32'h00200000);
        dir_op[1]  = 2'd1; dir_x[1]  = '{32'h06000000, 32'h07000000, 32'hE8000000};
        dir_res[1] = pack3(32'h40000000, 32'h7FFFFFFF, 32'h00000001);
        dir_op[2]  = 2'd1; dir_x[2]  = '{32'hE7000000, 0, 32'h01000000};
        dir_res[2] = pack3(32'h00000000, 32'h01000000, 32'h02000000);
        dir_op[3]  = 2'd2; dir_x[3]  = '{32'h01000000, 32'h04000000, 32'h00200000};
        dir_res[3] = pack3(32'h01000000, 32'h00400000, 32'h08000000);
        dir_op[4]  = 2'd2; dir_x[4]  = '{32'h0C000000, 1, 0};
        dir_res[4] = pack3(32'h00180000, 32'h7FFFFFFF, 32'h7FFFFFFF);
        dir_op[5]  = 2'd0; dir_x[5]  = '{0, 0, 0};
        dir_res[5] = pack3(32'h00600000, 32'h00600000, 32'h00600000);
        dir_op[6]  = 2'd0; dir_x[6]  = '{32'h02000000, 32'h02000000, 32'h02000000};
        dir_res[6] = pack3(32'h00600000, 32'h00600000, 32'h00600000);
        dir_op[7]  = 2'd0; dir_x[7]  = '{32'h30000000, 32'h30000000, 32'h30000000};
        dir_res[7] = pack3(32'h00600000, 32'h00600000, 32'h00600000);
        dir_op[8]  = 2'd0; dir_x[8]  = '{0, 0, 32'h01000000};
        dir_res[8] = pack3(32'h00400000, 32'h00400000, 32'h00800000);
        dir_op[9]  = 2'd3; dir_x[9]  = '{0, 0, 32'h01000000};
        dir_res[9] = pack3(32'h00400000, 32'h00400000, 32'h00800000);
        dir_op[10] = 2'd2; dir_x[10] = '{32'hFF000000, 32'h02000000, 32'h00800000};
        dir_res[10] = pack3(32'h7FFFFFFF, 32'h00800000, 32'h02000000);
        dir_op[11] = 2'd1; dir_x[11] = '{32'hFF800000, 32'h00800000, 32'h05800000};
        dir_res[11] = pack3(32'h00C00000, 32'h01800000, 32'h30000000);

        rst = 1; in_valid = 1; op = 0; x_pk = '0; pend_res = '0;
        tick(); tick();
        rst = 0; in_valid = 0;
        tick(); tick();

        // directed vectors back-to-back, mixed ops
        for (int i = 0; i < 12; i++) begin
            drive(dir_op[i], dir_x[i], dir_res[i]);
            tick();
        end
        in_valid = 0;
        for (int i = 0; i < 4; i++) tick();

        // randomized traffic checked against the model
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                o = 2'($urandom_range(0, 3));
                for (int i = 0; i < 3; i++) begin
                    case (o)
                        2'd1: xs[i] = int'($urandom_range(0, 40 << 24)) - (30 << 24);
                        2'd2: xs[i] = ($urandom_range(0, 9) == 0) ? -int'($urandom_range(0, 1000))
                                                                  : int'($urandom() >> $urandom_range(1, 31));
                        default: xs[i] = ($urandom_range(0, 4) == 0) ? int'($urandom())
                                       : int'($urandom_range(0, 32 << 24)) - (16 << 24);
                    endcase
                end
                drive(o, xs, model(o, xs));
            end else begin
                in_valid = 0;
            end
            tick();
        end
        in_valid = 0;
        for (int i = 0; i < 4; i++) tick();

        // reset while two vectors are in flight
        xs = '{0, 0, 32'h01000000};
        drive(2'd0, xs, model(2'd0, xs)); tick();
        xs = '{32'h01000000, 32'h02000000, 32'h03000000};
        drive(2'd1, xs, model(2'd1, xs)); tick();
        rst = 1; tick();
        chk("rst_valid", {95'd0, out_valid}, 96'd0);
        chk("rst_res", res_pk, 96'd0);
        in_valid = 0; tick();
        rst = 0; tick(); tick(); tick();
        xs = '{32'h0C000000, 32'h01000000, 32'h00200000};
        drive(2'd2, xs, model(2'd2, xs)); tick();
        in_valid = 0;
        for (int i = 0; i < 4; i++) tick();

        chk("drain", 96'(sb.size()), 96'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
